// File: rtl/coolgirl_irq_pkg.sv
// Shared definitions for the CoolGirl interrupt engine.
//   - irq_mode_e   : counting mode held in control[5:4]
//   - REG_*        : register select values on reg_addr
//   - CTRL_*       : bit positions inside the control register
package coolgirl_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_MODE_SCANLINE = 2'b00,
        IRQ_MODE_CPU_DOWN = 2'b01,
        IRQ_MODE_VRC      = 2'b10,
        IRQ_MODE_OFF      = 2'b11
    } irq_mode_e;

    localparam logic [2:0] REG_LATCH_LO = 3'd0;
    localparam logic [2:0] REG_LATCH_HI = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_RELOAD   = 3'd3;
    localparam logic [2:0] REG_ACK      = 3'd4;

    localparam int CTRL_IRQ_EN     = 0;
    localparam int CTRL_CNT_EN     = 1;
    localparam int CTRL_ACK_REEN   = 2;
    localparam int CTRL_CYCLE_MODE = 3;
    localparam int CTRL_MODE_LO    = 4;
    localparam int CTRL_MODE_HI    = 5;

endpackage

// File: rtl/coolgirl_a12_filter.sv
// PPU A12 rise detector for the scanline counter.
// Synchronises the raw A12 into the m2 domain, measures how long it has
// been low, and flags a rise only after a sufficiently long low period.
// Ports:
//   m2       in  : CPU clock
//   reset    in  : synchronous, active-high
//   ppu_a12  in  : raw PPU A12 (asynchronous)
//   a12_rise out : one-cycle pulse on a qualified A12 rise
module coolgirl_a12_filter #(
    parameter int A12_FILTER = 2
) (
    input  logic m2,
    input  logic reset,
    input  logic ppu_a12,
    output logic a12_rise
);

    localparam logic [2:0] LOW_MAX = 3'(A12_FILTER);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       a12_prev_q, a12_prev_d;
    logic [2:0] low_cnt_q, low_cnt_d;

    always_comb begin
        sync1_d    = ppu_a12;
        sync2_d    = sync1_q;
        a12_prev_d = sync2_q;
        low_cnt_d  = low_cnt_q;
        if (sync2_q) begin
            low_cnt_d = 3'd0;
        end else if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + 3'd1;
        end
    end

    // low_cnt_q still reflects the low run that preceded this rise,
    // because it only clears on the edge after sync2 goes high.
    assign a12_rise = sync2_q & ~a12_prev_q & (low_cnt_q == LOW_MAX);

    always_ff @(posedge m2) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            a12_prev_q <= 1'b0;
            low_cnt_q  <= 3'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            a12_prev_q <= a12_prev_d;
            low_cnt_q  <= low_cnt_d;
        end
    end

endmodule

// File: rtl/coolgirl_irq_engine.sv
// Multi-mode interrupt engine: MMC3 scanline counter, CPU-cycle
// down-counter, or VRC4 prescaled up-counter, selected by control[5:4].
// Ports:
//   m2          in  : CPU clock, all state on rising edge
//   reset       in  : synchronous, active-high
//   reg_we      in  : one-cycle register write strobe
//   reg_addr    in  : register select (latch lo/hi, control, reload, ack)
//   reg_data    in  : write data
//   ppu_a12     in  : raw PPU A12
//   irq         out : active-high interrupt request
//   counter_dbg out : current counter value
module coolgirl_irq_engine
    import coolgirl_irq_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int A12_FILTER      = 2,
    parameter int PRESCALE_PERIOD = 341,
    parameter int PRESCALE_STEP   = 3
) (
    input  logic                 m2,
    input  logic                 reset,
    input  logic                 reg_we,
    input  logic [2:0]           reg_addr,
    input  logic [7:0]           reg_data,
    input  logic                 ppu_a12,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] counter_dbg
);

    localparam logic signed [9:0]   PS_PERIOD = 10'(PRESCALE_PERIOD);
    localparam logic signed [9:0]   PS_STEP   = 10'(PRESCALE_STEP);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] counter_q, counter_d;
    logic [CNT_WIDTH-1:0] latch_q, latch_d;
    logic                 irq_en_q, irq_en_d;
    logic                 cnt_en_q, cnt_en_d;
    logic                 ack_reen_q, ack_reen_d;
    logic                 cycle_mode_q, cycle_mode_d;
    irq_mode_e            mode_q, mode_d;
    logic                 reload_flag_q, reload_flag_d;
    logic                 irq_q, irq_d;
    logic signed [9:0]    prescaler_q, prescaler_d;

    logic                 a12_rise;
    logic                 wr_latch_lo, wr_latch_hi, wr_ctrl, wr_reload, wr_ack;
    logic                 cnt_wr;
    logic                 scan_event;
    logic                 vrc_tick;
    logic                 irq_set;
    logic signed [9:0]    ps_next;
    logic [7:0]           cnt8;
    logic [15:0]          latch_hi_wr;
    irq_mode_e            ctrl_mode;

    coolgirl_a12_filter #(
        .A12_FILTER (A12_FILTER)
    ) u_a12_filter (
        .m2       (m2),
        .reset    (reset),
        .ppu_a12  (ppu_a12),
        .a12_rise (a12_rise)
    );

    always_comb begin
        counter_d     = counter_q;
        latch_d       = latch_q;
        irq_en_d      = irq_en_q;
        cnt_en_d      = cnt_en_q;
        ack_reen_d    = ack_reen_q;
        cycle_mode_d  = cycle_mode_q;
        mode_d        = mode_q;
        reload_flag_d = reload_flag_q;
        irq_d         = irq_q;
        prescaler_d   = prescaler_q;
        irq_set       = 1'b0;
        vrc_tick      = 1'b0;
        cnt8          = counter_q[7:0];
        ps_next       = prescaler_q - PS_STEP;
        // For CNT_WIDTH=8 the slice below keeps only the old low byte,
        // so a high-byte write becomes a no-op.
        latch_hi_wr   = {reg_data, latch_q[7:0]};
        ctrl_mode     = irq_mode_e'(reg_data[CTRL_MODE_HI:CTRL_MODE_LO]);

        wr_latch_lo = reg_we && (reg_addr == REG_LATCH_LO);
        wr_latch_hi = reg_we && (reg_addr == REG_LATCH_HI);
        wr_ctrl     = reg_we && (reg_addr == REG_CTRL);
        wr_reload   = reg_we && (reg_addr == REG_RELOAD);
        wr_ack      = reg_we && (reg_addr == REG_ACK);

        // Any write touching the counter or latch suppresses this cycle's count.
        cnt_wr = wr_latch_lo || wr_latch_hi
              || (wr_reload && (mode_q == IRQ_MODE_CPU_DOWN))
              || (wr_ctrl && (ctrl_mode == IRQ_MODE_VRC) && reg_data[CTRL_CNT_EN]);

        scan_event = (mode_q == IRQ_MODE_SCANLINE) && a12_rise && !cnt_wr;

        case (mode_q)
            IRQ_MODE_SCANLINE: begin
                if (scan_event) begin
                    // A reload write in the same cycle is consumed by this event.
                    if ((counter_q[7:0] == 8'd0) || reload_flag_q || wr_reload) begin
                        cnt8          = latch_q[7:0];
                        reload_flag_d = 1'b0;
                    end else begin
                        cnt8 = counter_q[7:0] - 8'd1;
                    end
                    counter_d[7:0] = cnt8;
                    if ((cnt8 == 8'd0) && irq_en_q) begin
                        irq_set = 1'b1;
                    end
                end
            end
            IRQ_MODE_CPU_DOWN: begin
                if (cnt_en_q && !cnt_wr) begin
                    counter_d = counter_q - CNT_ONE;
                    if ((counter_q == '0) && irq_en_q) begin
                        irq_set = 1'b1;
                    end
                end
            end
            IRQ_MODE_VRC: begin
                if (cnt_en_q) begin
                    if (cycle_mode_q) begin
                        vrc_tick = 1'b1;
                    end else if (ps_next[9] || (ps_next == '0)) begin
                        prescaler_d = ps_next + PS_PERIOD;
                        vrc_tick    = 1'b1;
                    end else begin
                        prescaler_d = ps_next;
                    end
                    if (vrc_tick && !cnt_wr) begin
                        if (counter_q[7:0] == 8'hFF) begin
                            counter_d[7:0] = latch_q[7:0];
                            irq_set        = irq_en_q;
                        end else begin
                            counter_d[7:0] = counter_q[7:0] + 8'd1;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (wr_latch_lo) begin
            latch_d[7:0] = reg_data;
        end
        if (wr_latch_hi) begin
            latch_d = latch_hi_wr[CNT_WIDTH-1:0];
        end
        if (wr_ctrl) begin
            irq_en_d     = reg_data[CTRL_IRQ_EN];
            cnt_en_d     = reg_data[CTRL_CNT_EN];
            ack_reen_d   = reg_data[CTRL_ACK_REEN];
            cycle_mode_d = reg_data[CTRL_CYCLE_MODE];
            mode_d       = ctrl_mode;
            if (ctrl_mode != mode_q) begin
                prescaler_d = PS_PERIOD;
            end
            if ((ctrl_mode == IRQ_MODE_VRC) && reg_data[CTRL_CNT_EN]) begin
                counter_d[7:0] = latch_q[7:0];
                prescaler_d    = PS_PERIOD;
                irq_d          = 1'b0;
            end
        end
        if (wr_reload) begin
            if ((mode_q == IRQ_MODE_SCANLINE) && !scan_event) begin
                reload_flag_d = 1'b1;
            end
            if (mode_q == IRQ_MODE_CPU_DOWN) begin
                counter_d = latch_q;
            end
        end
        if (wr_ack) begin
            irq_d = 1'b0;
            if (mode_q == IRQ_MODE_VRC) begin
                cnt_en_d = ack_reen_q;
            end
        end

        // A new event beats an acknowledge; disabling or mode off beats both.
        if (irq_set) begin
            irq_d = 1'b1;
        end
        if (!irq_en_d || (mode_d == IRQ_MODE_OFF)) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge m2) begin
        if (reset) begin
            counter_q     <= '0;
            latch_q       <= '0;
            irq_en_q      <= 1'b0;
            cnt_en_q      <= 1'b0;
            ack_reen_q    <= 1'b0;
            cycle_mode_q  <= 1'b0;
            mode_q        <= IRQ_MODE_SCANLINE;
            reload_flag_q <= 1'b0;
            irq_q         <= 1'b0;
            prescaler_q   <= PS_PERIOD;
        end else begin
            counter_q     <= counter_d;
            latch_q       <= latch_d;
            irq_en_q      <= irq_en_d;
            cnt_en_q      <= cnt_en_d;
            ack_reen_q    <= ack_reen_d;
            cycle_mode_q  <= cycle_mode_d;
            mode_q        <= mode_d;
            reload_flag_q <= reload_flag_d;
            irq_q         <= irq_d;
            prescaler_q   <= prescaler_d;
        end
    end

    assign irq         = irq_q;
    assign counter_dbg = counter_q;

endmodule

// File: tb/tb_coolgirl_irq_engine.sv
module tb_coolgirl_irq_engine;

    logic        m2;
    logic        reset;
    logic        reg_we;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        ppu_a12;
    logic        irq;
    logic [15:0] counter_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    coolgirl_irq_engine #(
        .CNT_WIDTH       (16),
        .A12_FILTER      (2),
        .PRESCALE_PERIOD (341),
        .PRESCALE_STEP   (3)
    ) dut (
        .m2          (m2),
        .reset       (reset),
        .reg_we      (reg_we),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .ppu_a12     (ppu_a12),
        .irq         (irq),
        .counter_dbg (counter_dbg)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        reg_we   = 1'b1;
        reg_addr = addr;
        reg_data = data;
        tick();
        reg_we   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // A12 is raised so it is first sampled high at edge k; counter and irq
    // must hold through k+1 and update at k+2. A12 then stays low long
    // enough to saturate the low-time filter.
    task automatic a12_rise_check(input string tag, input logic [15:0] cnt_before,
                                  input logic [15:0] cnt_after, input logic irq_before,
                                  input logic irq_after);
        ppu_a12 = 1'b1;
        tick();
        check({tag, "_k"}, 32'(counter_dbg), 32'(cnt_before));
        tick();
        check({tag, "_k1"}, 32'(counter_dbg), 32'(cnt_before));
        check({tag, "_k1_irq"}, 32'(irq), 32'(irq_before));
        tick();
        check({tag, "_k2"}, 32'(counter_dbg), 32'(cnt_after));
        check({tag, "_k2_irq"}, 32'(irq), 32'(irq_after));
        ppu_a12 = 1'b0;
        tick_n(4);
    endtask

    initial begin
        reset    = 1'b1;
        reg_we   = 1'b0;
        reg_addr = 3'd0;
        reg_data = 8'd0;
        ppu_a12  = 1'b0;
        tick_n(2);
        check("reset_counter", 32'(counter_dbg), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        tick_n(3);

        // Scanline: latch 3, irq_en, reload flag, four rises 3,2,1,0
        wr(3'd0, 8'd3);
        wr(3'd2, 8'h01);
        wr(3'd3, 8'h00);
        check("scan_reload_flag_only", 32'(counter_dbg), 32'h0);
        a12_rise_check("scan_r1", 16'd0, 16'd3, 1'b0, 1'b0);
        a12_rise_check("scan_r2", 16'd3, 16'd2, 1'b0, 1'b0);
        a12_rise_check("scan_r3", 16'd2, 16'd1, 1'b0, 1'b0);
        a12_rise_check("scan_r4", 16'd1, 16'd0, 1'b0, 1'b1);
        // counter at 0 reloads from latch on the next rise
        a12_rise_check("scan_r5", 16'd0, 16'd3, 1'b1, 1'b1);
        ppu_a12 = 1'b1;
        tick_n(5);
        check("scan_r6", 32'(counter_dbg), 32'd2);
        // glitch: one low cycle only, filter needs two
        ppu_a12 = 1'b0;
        tick();
        ppu_a12 = 1'b1;
        tick_n(5);
        check("scan_glitch", 32'(counter_dbg), 32'd2);
        wr(3'd2, 8'h00);
        check("scan_disable_clears_irq", 32'(irq), 32'h0);
        ppu_a12 = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick_n(3);

        // cpu_down
        wr(3'd2, 8'h11);
        wr(3'd1, 8'h01);
        wr(3'd0, 8'h02);
        wr(3'd3, 8'h00);
        check("cpu_reload_hi", 32'(counter_dbg), 32'h0102);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h00);
        check("cpu_reload", 32'(counter_dbg), 32'h0002);
        wr(3'd2, 8'h13);
        check("cpu_en_edge", 32'(counter_dbg), 32'h0002);
        tick();
        check("cpu_1", 32'(counter_dbg), 32'h0001);
        tick();
        check("cpu_0", 32'(counter_dbg), 32'h0000);
        check("cpu_0_irq", 32'(irq), 32'h0);
        tick();
        check("cpu_wrap", 32'(counter_dbg), 32'hFFFF);
        check("cpu_wrap_irq", 32'(irq), 32'h1);
        wr(3'd4, 8'h00);
        check("cpu_ack_irq", 32'(irq), 32'h0);
        check("cpu_ack_cnt", 32'(counter_dbg), 32'hFFFE);
        tick();
        check("cpu_fffd", 32'(counter_dbg), 32'hFFFD);
        reset = 1'b1;
        tick();
        check("midreset_counter", 32'(counter_dbg), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        tick_n(5);
        check("idle_counter", 32'(counter_dbg), 32'h0);
        check("idle_irq", 32'(irq), 32'h0);

        // vrc prescaled: 341 step 3 -> tick every 114 cycles
        wr(3'd0, 8'hFE);
        wr(3'd2, 8'h23);
        check("vrc_load", 32'(counter_dbg), 32'h00FE);
        check("vrc_load_irq", 32'(irq), 32'h0);
        tick_n(113);
        check("vrc_pre_tick1", 32'(counter_dbg), 32'h00FE);
        tick();
        check("vrc_tick1", 32'(counter_dbg), 32'h00FF);
        tick_n(113);
        check("vrc_pre_tick2", 32'(counter_dbg), 32'h00FF);
        check("vrc_pre_tick2_irq", 32'(irq), 32'h0);
        tick();
        check("vrc_tick2", 32'(counter_dbg), 32'h00FE);
        check("vrc_tick2_irq", 32'(irq), 32'h1);
        wr(3'd4, 8'h00);
        check("vrc_ack_irq", 32'(irq), 32'h0);
        tick_n(240);
        check("vrc_stopped", 32'(counter_dbg), 32'h00FE);
        check("vrc_stopped_irq", 32'(irq), 32'h0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick_n(2);

        // vrc cycle mode
        wr(3'd0, 8'hFF);
        wr(3'd2, 8'h2B);
        check("cyc_load", 32'(counter_dbg), 32'h00FF);
        check("cyc_load_irq", 32'(irq), 32'h0);
        tick();
        check("cyc_first_irq", 32'(irq), 32'h1);
        check("cyc_first_cnt", 32'(counter_dbg), 32'h00FF);
        wr(3'd4, 8'h00);
        check("cyc_ack_vs_set", 32'(irq), 32'h1);
        tick_n(3);
        check("cyc_held_irq", 32'(irq), 32'h1);
        wr(3'd4, 8'h00);
        check("cyc_ack2", 32'(irq), 32'h0);
        wr(3'd2, 8'h2B);
        tick();
        check("cyc_rearm_irq", 32'(irq), 32'h1);
        wr(3'd2, 8'h33);
        check("off_irq", 32'(irq), 32'h0);
        tick_n(3);
        check("off_irq_held", 32'(irq), 32'h0);
        check("off_counter", 32'(counter_dbg), 32'h00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
